// File: rtl/spi_pkg.sv
// Shared constants and state encodings for the SPI receive-side collector
// and related byte-stream helpers.
package spi_pkg;

    localparam int BYTE_W          = 8;
    localparam int ACK_TIMEOUT_DEF = 255;
    localparam int SETTLE_W        = 4;
    localparam int TIMEOUT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ACK    = 2'd3
    } coll_state_e;

endpackage

// File: rtl/spi_rx_collector_sync_fifo.sv
// Single-clock first-word fall-through FIFO; dout always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/spi_rx_collector.sv
// Collects bytes from the SPI block on each ready rise, acknowledges them,
// and streams them out of a FIFO over valid/ready.
//
// state   | meaning
// IDLE    | waiting for a spi_ready rise
// SETTLE  | counting down before sampling spi_data
// HOLD    | byte latched, waiting for FIFO space
// ACK     | spi_received high until spi_ready falls or the timeout expires
module spi_rx_collector
    import spi_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int SKIP_FIRST    = 1,
    parameter int SETTLE        = 2,
    parameter int STALL_ON_FULL = 0,
    parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_ready,
    input  logic [7:0]              spi_data,
    output logic                    spi_received,
    output logic                    m_valid,
    output logic [7:0]              m_data,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    timeout_err,
    input  logic                    clr_err
);

    coll_state_e          state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 skip_q, skip_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic [BYTE_W-1:0]    hold_data_q, hold_data_d;
    logic                 received_q, received_d;
    logic                 overflow_q, overflow_d;
    logic                 timeout_q, timeout_d;

    logic                 rise;
    logic                 pop;
    logic                 space;
    logic                 ovf_set;
    logic                 to_set;
    logic                 fifo_push;
    logic [BYTE_W-1:0]    fifo_din;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign rise    = spi_ready & ~ready_q;
    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & m_ready;
    assign space   = ~fifo_full | pop;

    always_comb begin
        state_d      = state_q;
        ready_d      = spi_ready;
        skip_d       = skip_q;
        settle_cnt_d = settle_cnt_q;
        tcnt_d       = tcnt_q;
        hold_data_d  = hold_data_q;
        fifo_push    = 1'b0;
        fifo_din     = spi_data;
        ovf_set      = 1'b0;
        to_set       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    if (skip_q) begin
                        // Configuration acknowledge from the SPI block: ack it, keep nothing.
                        skip_d  = 1'b0;
                        tcnt_d  = '0;
                        state_d = ST_ACK;
                    end else begin
                        settle_cnt_d = SETTLE_W'(SETTLE);
                        state_d      = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!spi_ready) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == '0) begin
                    if (space) begin
                        fifo_push = 1'b1;
                        tcnt_d    = '0;
                        state_d   = ST_ACK;
                    end else if (STALL_ON_FULL != 0) begin
                        hold_data_d = spi_data;
                        state_d     = ST_HOLD;
                    end else begin
                        ovf_set = 1'b1;
                        tcnt_d  = '0;
                        state_d = ST_ACK;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                fifo_din = hold_data_q;
                if (space) begin
                    fifo_push = 1'b1;
                    tcnt_d    = '0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!spi_ready) begin
                    state_d = ST_IDLE;
                end else if (tcnt_q == TIMEOUT_W'(ACK_TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        received_d = (state_d == ST_ACK);
        overflow_d = (overflow_q & ~clr_err) | ovf_set;
        timeout_d  = (timeout_q & ~clr_err) | to_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            skip_q       <= (SKIP_FIRST != 0);
            settle_cnt_q <= '0;
            tcnt_q       <= '0;
            hold_data_q  <= '0;
            received_q   <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            skip_q       <= skip_d;
            settle_cnt_q <= settle_cnt_d;
            tcnt_q       <= tcnt_d;
            hold_data_q  <= hold_data_d;
            received_q   <= received_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (m_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign spi_received = received_q;
    assign overflow     = overflow_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_spi_rx_collector.sv
// Bench for spi_rx_collector: two configurations driven by a simple SPI-side
// handshake, compared against a queue-based model of the collected byte stream.
module tb_spi_rx_collector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rdy [2];
    logic [7:0] dat [2];
    logic       rcv [2];
    logic       mv  [2];
    logic [7:0] md  [2];
    logic       mr  [2];
    logic       ovf [2];
    logic       toe [2];
    logic       clr [2];
    logic [3:0] lvl_a;
    logic [1:0] lvl_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    bit         skip_m [2];
    bit         ovf_m  [2];

    spi_rx_collector #(
        .DEPTH(8), .SKIP_FIRST(1), .SETTLE(2), .STALL_ON_FULL(0), .ACK_TIMEOUT(255)
    ) u_a (
        .clk(clk), .rst(rst), .spi_ready(rdy[0]), .spi_data(dat[0]),
        .spi_received(rcv[0]), .m_valid(mv[0]), .m_data(md[0]), .m_ready(mr[0]),
        .level(lvl_a), .overflow(ovf[0]), .timeout_err(toe[0]), .clr_err(clr[0])
    );

    spi_rx_collector #(
        .DEPTH(2), .SKIP_FIRST(1), .SETTLE(0), .STALL_ON_FULL(1), .ACK_TIMEOUT(20)
    ) u_b (
        .clk(clk), .rst(rst), .spi_ready(rdy[1]), .spi_data(dat[1]),
        .spi_received(rcv[1]), .m_valid(mv[1]), .m_data(md[1]), .m_ready(mr[1]),
        .level(lvl_b), .overflow(ovf[1]), .timeout_err(toe[1]), .clr_err(clr[1])
    );

    function automatic int depth_of(int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic int settle_of(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int tmo_of(int i);
        return (i == 0) ? 255 : 20;
    endfunction

    function automatic int lvl(int i);
        return (i == 0) ? int'(lvl_a) : int'(lvl_b);
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] qhead(int i);
        if (qsize(i) == 0) return 8'h00;
        return (i == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic qpush(int i, logic [7:0] d);
        if (i == 0) mq0.push_back(d);
        else        mq1.push_back(d);
    endtask

    task automatic qpop(int i);
        if (i == 0) void'(mq0.pop_front());
        else        void'(mq1.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(int i);
        chk("level", lvl(i), qsize(i));
        chk("m_valid", mv[i], qsize(i) > 0);
        if (qsize(i) > 0) chk("m_data", md[i], qhead(i));
        chk("overflow", ovf[i], ovf_m[i]);
    endtask

    task automatic reset_model();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            skip_m[k] = 1'b1;
            ovf_m[k]  = 1'b0;
        end
    endtask

    // One SPI transfer: raise ready, wait for the ack, then release ready.
    task automatic pulse(int i, logic [7:0] d);
        int n;
        int exp_n;
        exp_n  = skip_m[i] ? 1 : settle_of(i) + 2;
        dat[i] = d;
        rdy[i] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rcv[i] && n < 60);
        chk("ack_latency", n, exp_n);
        if (skip_m[i])                     skip_m[i] = 1'b0;
        else if (qsize(i) < depth_of(i))   qpush(i, d);
        else                               ovf_m[i] = 1'b1;
        check_stream(i);
        rdy[i] = 1'b0;
        tick();
        chk("ack_release", rcv[i], 1'b0);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic drain(int i);
        int guard;
        guard = 0;
        while (qsize(i) > 0 && guard < 200) begin
            chk("drain_valid", mv[i], 1'b1);
            chk("drain_data", md[i], qhead(i));
            chk("drain_level", lvl(i), qsize(i));
            mr[i] = ($urandom_range(0, 1) == 1);
            tick();
            if (mr[i]) qpop(i);
            guard++;
        end
        mr[i] = 1'b0;
        chk("drain_bound", guard < 200, 1'b1);
        chk("empty_valid", mv[i], 1'b0);
        chk("empty_level", lvl(i), 0);
    endtask

    task automatic clear_err(int i);
        clr[i] = 1'b1;
        tick();
        clr[i] = 1'b0;
        ovf_m[i] = 1'b0;
        chk("clr_overflow", ovf[i], 1'b0);
        chk("clr_timeout", toe[i], 1'b0);
    endtask

    task automatic timeout_test(int i);
        int n;
        int hi;
        dat[i] = 8'($urandom);
        rdy[i] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rcv[i] && n < 60);
        chk("tmo_ack_seen", rcv[i], 1'b1);
        qpush(i, dat[i]);
        hi = 0;
        while (rcv[i] && hi < 400) begin
            hi++;
            tick();
        end
        chk("tmo_ack_cycles", hi, tmo_of(i));
        chk("tmo_flag", toe[i], 1'b1);
        repeat (45) tick();
        chk("tmo_no_reack", rcv[i], 1'b0);
        check_stream(i);
        rdy[i] = 1'b0;
        tick();
        clear_err(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = 1'b0; dat[k] = 8'h00; mr[k] = 1'b0; clr[k] = 1'b0;
        end
        reset_model();
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_received", rcv[k], 1'b0);
            chk("rst_valid", mv[k], 1'b0);
            chk("rst_level", lvl(k), 0);
            chk("rst_overflow", ovf[k], 1'b0);
            chk("rst_timeout", toe[k], 1'b0);
        end
        rst = 1'b0;
        tick();

        // Config ack skipped, then first real byte.
        pulse(0, 8'hA5);
        pulse(0, 8'h3C);
        drain(0);

        pulse(0, 8'h11);
        pulse(0, 8'h22);
        pulse(0, 8'h33);
        drain(0);

        pulse(1, 8'h5A);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(1, 8)) pulse(0, 8'($urandom));
            drain(0);
            repeat ($urandom_range(1, 2)) pulse(1, 8'($urandom));
            drain(1);
        end

        // Overflow on the dropping configuration.
        repeat (10) pulse(0, 8'($urandom));
        clear_err(0);
        drain(0);

        // Stall on the holding configuration.
        pulse(1, 8'($urandom));
        pulse(1, 8'($urandom));
        dat[1] = 8'h77;
        rdy[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("stall_no_ack", rcv[1], 1'b0);
        end
        chk("stall_level", lvl(1), 2);
        mr[1] = 1'b1;
        tick();
        mr[1] = 1'b0;
        qpop(1);
        qpush(1, 8'h77);
        chk("stall_ack", rcv[1], 1'b1);
        check_stream(1);
        rdy[1] = 1'b0;
        tick();
        chk("stall_release", rcv[1], 1'b0);
        chk("stall_no_overflow", ovf[1], 1'b0);
        drain(1);

        timeout_test(0);
        drain(0);
        timeout_test(1);
        drain(1);

        // Reset while in SETTLE.
        pulse(0, 8'h9E);
        dat[0] = 8'h44;
        rdy[0] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_settle_received", rcv[0], 1'b0);
        chk("rst_settle_level", lvl(0), 0);
        chk("rst_settle_valid", mv[0], 1'b0);
        rdy[0] = 1'b0;
        tick();
        rst = 1'b0;
        reset_model();
        tick();
        pulse(0, 8'hC3);
        pulse(0, 8'h5D);

        // Reset while acknowledging.
        dat[0] = 8'h66;
        rdy[0] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rcv[0] && n < 60);
        chk("rst_ack_seen", rcv[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_ack_received", rcv[0], 1'b0);
        chk("rst_ack_level", lvl(0), 0);
        rdy[0] = 1'b0;
        tick();
        rst = 1'b0;
        reset_model();
        tick();
        pulse(0, 8'hE1);
        pulse(0, 8'h0F);
        drain(0);
        pulse(1, 8'hB2);
        pulse(1, 8'h4B);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
